// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- execute-stage multiply/divide unit for the five-stage MIPS core.
//
// Runs mult/multu/div/divu with a fixed busy period, owns the HI/LO
// registers, executes mthi/mtlo and returns HI/LO for mfhi/mflo.
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   reset     asynchronous, active-low reset
//   E_MDOp    0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//             7 mfhi, 8 mflo, anything else is treated as none
//   E_Start   high in the cycle a mult/multu/div/divu sits in E
//   E_RS      rs operand (dividend / multiplicand / mthi-mtlo source)
//   E_RT      rt operand (divisor / multiplier)
//   Req       exception/interrupt flush of the E-stage instruction
//   E_Busy    high while a computation is in flight
//   E_MDData  HI for mfhi, LO for mflo, otherwise 0 (combinational)
//   E_HI/E_LO current HI/LO contents
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic        E_Start,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        Req,
  output logic        E_Busy,
  output logic [31:0] E_MDData,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  // Both latencies are limited to 1..15, so four bits always suffice.
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      hi, hi_next;
  logic [31:0]      lo, lo_next;
  logic [31:0]      pend_hi, pend_hi_next;
  logic [31:0]      pend_lo, pend_lo_next;
  logic             busy, busy_next;

  logic             op_mult, op_multu, op_div, op_divu, op_start;
  logic [63:0]      prod_s, prod_u;
  logic             rs_neg, rt_neg, rt_zero;
  logic [31:0]      abs_rs, abs_rt, abs_rt_safe, rt_safe;
  logic [31:0]      q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [31:0]      res_hi, res_lo;

  assign op_mult  = (E_MDOp == 4'd1);
  assign op_multu = (E_MDOp == 4'd2);
  assign op_div   = (E_MDOp == 4'd3);
  assign op_divu  = (E_MDOp == 4'd4);
  assign op_start = op_mult | op_multu | op_div | op_divu;

  // Products are formed on explicitly widened operands so the signed and
  // unsigned flavours differ only in how the upper 32 bits are filled.
  assign prod_s = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
  assign prod_u = {32'd0, E_RS} * {32'd0, E_RT};

  // Signed division is done on magnitudes and the signs reapplied; this
  // makes 0x80000000 / -1 fall out naturally as LO=0x80000000, HI=0.
  // A zero divisor is replaced by 1 only to keep the dividers defined;
  // the result is discarded in that case anyway.
  assign rs_neg      = E_RS[31];
  assign rt_neg      = E_RT[31];
  assign rt_zero     = (E_RT == 32'd0);
  assign abs_rs      = rs_neg ? (32'd0 - E_RS) : E_RS;
  assign abs_rt      = rt_neg ? (32'd0 - E_RT) : E_RT;
  assign abs_rt_safe = rt_zero ? 32'd1 : abs_rt;
  assign rt_safe     = rt_zero ? 32'd1 : E_RT;
  assign q_mag       = abs_rs / abs_rt_safe;
  assign r_mag       = abs_rs % abs_rt_safe;
  assign q_s         = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s         = rs_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u         = E_RS / rt_safe;
  assign r_u         = E_RS % rt_safe;

  // Result selection; division by zero re-latches the current HI/LO so the
  // commit at the end of the busy period leaves them unchanged.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    if (op_mult) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (op_multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (op_div && !rt_zero) begin
      res_hi = r_s;
      res_lo = q_s;
    end else if (op_divu && !rt_zero) begin
      res_hi = r_u;
      res_lo = q_u;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      busy    <= busy_next;
    end
  end

  // Next-state logic. A flush only blocks new work in IDLE; an operation
  // already running came from a committed instruction and always finishes.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    busy_next    = busy;
    case (state)
      IDLE: begin
        if (!Req) begin
          if (E_Start && op_start) begin
            pend_hi_next = res_hi;
            pend_lo_next = res_lo;
            cnt_next     = (op_mult || op_multu) ? CNT_W'(MULT_CYCLES)
                                                 : CNT_W'(DIV_CYCLES);
            busy_next    = 1'b1;
            state_next   = BUSY;
          end else if (E_MDOp == 4'd5) begin
            hi_next = E_RS;
          end else if (E_MDOp == 4'd6) begin
            lo_next = E_RS;
          end
        end
      end
      BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          cnt_next   = '0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    E_MDData = 32'd0;
    if (E_MDOp == 4'd7) begin
      E_MDData = hi;
    end else if (E_MDOp == 4'd8) begin
      E_MDData = lo;
    end
  end

  assign E_Busy = busy;
  assign E_HI   = hi;
  assign E_LO   = lo;

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu. Expected HI/LO pairs go into a
// scoreboard queue when an operation is issued and are popped and compared
// once E_Busy falls.
// ---------------------------------------------------------------------------
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic        E_Start;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        Req;
  logic        E_Busy;
  logic [31:0] E_MDData;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int          total;
  int          bad;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;
  logic [63:0] sb[$];

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .E_MDOp  (E_MDOp),
    .E_Start (E_Start),
    .E_RS    (E_RS),
    .E_RT    (E_RT),
    .Req     (Req),
    .E_Busy  (E_Busy),
    .E_MDData(E_MDData),
    .E_HI    (E_HI),
    .E_LO    (E_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result for an operation, returned as {HI, LO}.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [63:0] prev);
    longint          ps;
    longint unsigned pu;
    int              qs, rsm;
    model = prev;
    case (op)
      4'd1: begin
        ps = longint'($signed(rs)) * longint'($signed(rt));
        model = ps;
      end
      4'd2: begin
        pu = longint'(rs) * longint'(rt);
        model = pu;
      end
      4'd3: begin
        if (rt == 32'd0) model = prev;
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          qs  = $signed(rs) / $signed(rt);
          rsm = $signed(rs) % $signed(rt);
          model = {rsm, qs};
        end
      end
      4'd4: begin
        if (rt != 32'd0) model = {rs % rt, rs / rt};
      end
      default: model = prev;
    endcase
  endfunction

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v, input logic req);
    @(negedge clk);
    E_MDOp = op;
    E_RS   = v;
    Req    = req;
    @(negedge clk);
    E_MDOp = 4'd0;
    Req    = 1'b0;
    if (!req) begin
      if (op == 4'd5) cur_hi = v;
      else cur_lo = v;
    end
  endtask

  // Issues one operation, counts busy cycles, then checks the scoreboard
  // entry against HI/LO. mid_req / mid_start inject a flush or a stray
  // start during the second busy cycle.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int n_exp, input bit mid_req,
                        input bit mid_start);
    int          cnt;
    logic [63:0] exp;
    @(negedge clk);
    E_MDOp  = op;
    E_Start = 1'b1;
    E_RS    = rs;
    E_RT    = rt;
    sb.push_back(model(op, rs, rt, {cur_hi, cur_lo}));
    @(negedge clk);
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    cnt = 0;
    while (E_Busy && cnt < 50) begin
      cnt++;
      if (cnt == 2 && mid_req) Req = 1'b1;
      if (cnt == 2 && mid_start) begin
        E_Start = 1'b1;
        E_MDOp  = 4'd1;
        E_RS    = 32'd7;
        E_RT    = 32'd9;
      end else if (cnt == 3) begin
        E_Start = 1'b0;
        E_MDOp  = 4'd0;
      end
      @(negedge clk);
    end
    Req     = 1'b0;
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    total++;
    if (cnt !== n_exp) begin
      bad++;
      $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, cnt, n_exp);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s scoreboard: got empty expected one entry", name);
    end else begin
      exp = sb.pop_front();
      if ({E_HI, E_LO} !== exp) begin
        bad++;
        $display("[TB] FAIL %s hilo: got %h_%h expected %h_%h", name, E_HI, E_LO,
                 exp[63:32], exp[31:0]);
      end
      cur_hi = exp[63:32];
      cur_lo = exp[31:0];
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    total++;
    if ({E_Busy, E_HI, E_LO} !== 65'd0) begin
      bad++;
      $display("[TB] FAIL reset_init: got busy=%b hi=%h lo=%h expected 0/0/0", E_Busy, E_HI, E_LO);
    end
    @(negedge clk);
    reset = 1'b1;
    do_mt(4'd5, 32'h1234_5678, 1'b0);
    do_mt(4'd6, 32'h9ABC_DEF0, 1'b0);
    total++;
    if ({E_HI, E_LO} !== {cur_hi, cur_lo}) begin
      bad++;
      $display("[TB] FAIL mt_preload: got %h_%h expected %h_%h", E_HI, E_LO, cur_hi, cur_lo);
    end
    // Start a mult and drop reset between edges while it is running.
    @(negedge clk);
    E_MDOp  = 4'd1;
    E_Start = 1'b1;
    E_RS    = 32'd3;
    E_RT    = 32'd4;
    @(negedge clk);
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({E_Busy, E_HI, E_LO} !== 65'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got busy=%b hi=%h lo=%h expected 0/0/0", E_Busy, E_HI, E_LO);
    end
    @(negedge clk);
    reset  = 1'b1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    repeat (6) @(negedge clk);
    total++;
    if ({E_Busy, E_HI, E_LO} !== 65'd0) begin
      bad++;
      $display("[TB] FAIL reset_discard: got busy=%b hi=%h lo=%h expected 0/0/0", E_Busy, E_HI, E_LO);
    end
  endtask

  task automatic test_mult;
    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0);
    total++;
    if ({E_HI, E_LO} !== 64'h0000_0001_FFFF_FFFE) begin
      bad++;
      $display("[TB] FAIL multu_const: got %h_%h expected 00000001_fffffffe", E_HI, E_LO);
    end
  endtask

  task automatic test_div;
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 1'b0);
    total++;
    if ({E_HI, E_LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++;
      $display("[TB] FAIL div_const: got %h_%h expected ffffffff_fffffffd", E_HI, E_LO);
    end
    run_op("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 1'b0);
    total++;
    if ({E_HI, E_LO} !== 64'h0000_0001_7FFF_FFFC) begin
      bad++;
      $display("[TB] FAIL divu_const: got %h_%h expected 00000001_7ffffffc", E_HI, E_LO);
    end
  endtask

  task automatic test_div_edge;
    do_mt(4'd5, 32'h11, 1'b0);
    do_mt(4'd6, 32'h22, 1'b0);
    run_op("div_zero", 4'd3, 32'd100, 32'd0, 10, 1'b0, 1'b0);
    total++;
    if ({E_HI, E_LO} !== {32'h11, 32'h22}) begin
      bad++;
      $display("[TB] FAIL div_zero_const: got %h_%h expected 00000011_00000022", E_HI, E_LO);
    end
    run_op("divu_zero", 4'd4, 32'd100, 32'd0, 10, 1'b0, 1'b0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 1'b0);
    total++;
    if ({E_HI, E_LO} !== 64'h0000_0000_8000_0000) begin
      bad++;
      $display("[TB] FAIL div_ovf_const: got %h_%h expected 00000000_80000000", E_HI, E_LO);
    end
  endtask

  task automatic test_req;
    int busy_seen;
    @(negedge clk);
    E_MDOp  = 4'd1;
    E_Start = 1'b1;
    E_RS    = 32'd5;
    E_RT    = 32'd6;
    Req     = 1'b1;
    @(negedge clk);
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    Req     = 1'b0;
    busy_seen = 0;
    repeat (6) begin
      if (E_Busy) busy_seen++;
      @(negedge clk);
    end
    total++;
    if (busy_seen !== 0 || {E_HI, E_LO} !== {cur_hi, cur_lo}) begin
      bad++;
      $display("[TB] FAIL req_flush: got busy_cycles=%0d hilo=%h_%h expected 0 %h_%h",
               busy_seen, E_HI, E_LO, cur_hi, cur_lo);
    end
    do_mt(4'd5, 32'hCAFE_F00D, 1'b1);
    total++;
    if (E_HI !== cur_hi) begin
      bad++;
      $display("[TB] FAIL req_mthi: got %h expected %h", E_HI, cur_hi);
    end
    run_op("req_busy", 4'd2, 32'h0001_0000, 32'h0003_0000, 5, 1'b1, 1'b0);
    run_op("start_busy", 4'd4, 32'd1000, 32'd7, 10, 1'b0, 1'b1);
    run_op("after_busy", 4'd1, 32'hFFFF_FFFD, 32'd7, 5, 1'b0, 1'b0);
  endtask

  task automatic test_mfhi;
    do_mt(4'd5, 32'hDEAD_BEEF, 1'b0);
    E_MDOp = 4'd7;
    #1;
    total++;
    if (E_MDData !== 32'hDEAD_BEEF) begin
      bad++;
      $display("[TB] FAIL mfhi: got %h expected deadbeef", E_MDData);
    end
    E_MDOp = 4'd8;
    #1;
    total++;
    if (E_MDData !== cur_lo) begin
      bad++;
      $display("[TB] FAIL mflo: got %h expected %h", E_MDData, cur_lo);
    end
    E_MDOp = 4'd0;
    #1;
    total++;
    if (E_MDData !== 32'd0) begin
      bad++;
      $display("[TB] FAIL md_none: got %h expected 00000000", E_MDData);
    end
    E_MDOp = 4'd12;
    #1;
    total++;
    if (E_MDData !== 32'd0) begin
      bad++;
      $display("[TB] FAIL md_other: got %h expected 00000000", E_MDData);
    end
    E_MDOp = 4'd0;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 3) b = b >> 20;
      run_op("random", op, a, b, (op <= 4'd2) ? 5 : 10, 1'b0, 1'b0);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cur_hi  = 32'd0;
    cur_lo  = 32'd0;
    E_MDOp  = 4'd0;
    E_Start = 1'b0;
    E_RS    = 32'd0;
    E_RT    = 32'd0;
    Req     = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_req();
    test_mfhi();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage pipelined MIPS core. It performs mult/multu/div/divu with fixed multi-cycle latency and owns the HI/LO registers. It also executes mthi/mtlo and returns HI or LO for mfhi/mflo on E_MDData. E_MDData is captured by the E/M pipeline register and arrives in the M stage as the MD data input of the M-stage register-write select.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- E_MDOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others = none
- E_Start  in  1  high in the cycle a mult/multu/div/divu is in E
- E_RS  in  32  forwarded rs operand (dividend, multiplicand, mthi/mtlo source)
- E_RT  in  32  forwarded rt operand (divisor, multiplier)
- Req  in  1  exception/interrupt flush; E-stage instruction is being cancelled
- E_Busy  out  1  computation in progress
- E_MDData  out  32  HI when E_MDOp=7, LO when E_MDOp=8, else 0; combinational from current HI/LO
- E_HI, E_LO  out  32  current HI/LO register contents

## Operation
- State is held in the following registers:
  - HI and LO: 32 bits each.
  - Pending HI and LO results.
  - A down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
  - E_Busy flag.
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - On E_Start=1, Req=0, and E_MDOp in 1..4:
    - Compute the result from E_RS/E_RT.
    - Latch it into the pending registers.
    - Load the counter with MULT_CYCLES or DIV_CYCLES.
    - Set E_Busy and go to BUSY.
  - mthi (mtlo) with Req=0 writes E_RS to HI (LO) at the clock edge.
- BUSY:
  - The counter decrements each cycle.
  - When the counter reaches 1, the next edge copies pending to HI/LO, clears E_Busy and returns to IDLE.
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero: HI/LO are left unchanged at completion, but the busy period still elapses.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Req=1:
  - E_Start and mthi/mtlo are ignored.
  - An operation already in BUSY always completes; it was issued by a committed instruction.
- E_Start or mthi/mtlo while BUSY is ignored. The hazard unit stalls on E_Start|E_Busy, so this never occurs legally.
- mfhi/mflo never modify state.

## Timing
- Reset (reset=0, asynchronous) forces HI=0, LO=0, counter=0, E_Busy=0, state IDLE.
- Reset asserted mid-operation aborts the operation; the pending result is discarded.
- Operands are sampled at edge T, the first edge with E_Start=1.
- E_Busy is high for cycles T+1 .. T+N, where N is MULT_CYCLES or DIV_CYCLES.
- New HI/LO are visible in cycle T+N+1, the same cycle E_Busy is low.
- Back-to-back operations: a new E_Start is accepted in cycle T+N+1.
- mthi/mtlo take effect at the edge ending their E cycle and are visible on E_HI/E_LO one cycle later.
- E_MDData has zero latency from E_MDOp and reflects HI/LO as of the start of the current cycle.

## Test plan
- **Reset:** reset low mid-run → E_Busy=0, E_HI=E_LO=0 immediately, before the next clk edge.
- **mult/multu:**
  - Stimulus: mult with E_RS=0xFFFFFFFF, E_RT=2, E_Start for 1 cycle.
  - Required: E_Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Repeat as multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- **div/divu:**
  - div with E_RS=0xFFFFFFF9 (-7), E_RT=2 → E_Busy high exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- **Divide edge cases:**
  - Preload HI=0x11, LO=0x22 via mthi/mtlo, then div by 0 → 10 busy cycles, HI/LO still 0x11/0x22.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Req and ignored ops:**
  - mult with Req=1 → E_Busy stays 0 and HI/LO are unchanged.
  - Req asserted during BUSY → the operation still completes on schedule.
  - E_Start during BUSY → ignored.
- **mthi/mfhi:**
  - mthi with E_RS=0xDEADBEEF, next cycle E_MDOp=7 → E_MDData=0xDEADBEEF.
  - E_MDOp=8 → E_MDData=LO.
  - E_MDOp=0 → E_MDData=0.
